tlb_set_assoc: RTL and testbench

Parametrised set-associative TLB with storage, a one-cycle registered lookup pipeline, fill with replacement, and single-entry and full invalidation. It sits between the load/store address-generation stage and the page-table walker. Lookups arrive on a valid/ready request port and return one cycle later. The walker installs translations through the fill port, and the OS/fence path drives the invalidate port.

---
 rtl/tlb_pkg.sv | 23 ++
 rtl/tlb_way_match.sv | 38 +++
 rtl/tlb_set_assoc.sv | 257 +++++++++++++++++++++++++
 tb/tb_tlb_set_assoc.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared definitions for the set-associative TLB: permission bit positions,
// controller states and log2 width helpers.
package tlb_pkg;

    localparam int unsigned PERM_R = 0;
    localparam int unsigned PERM_W = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } tlb_state_e;

    // Width of an index into n items; never narrower than one bit.
    function automatic int unsigned log2_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_NUM_SETS = 16;
    localparam int unsigned DEF_NUM_WAYS = 4;
    localparam int unsigned SET_BITS     = log2_width(DEF_NUM_SETS);
    localparam int unsigned WAY_BITS     = log2_width(DEF_NUM_WAYS);

endpackage

// File: rtl/tlb_way_match.sv
// Compares one set's ways against a VPN; the lowest-indexed valid match wins
// and its way number, PPN and permissions are forwarded.
module tlb_way_match #(
    parameter int unsigned NUM_WAYS = 4,
    parameter int unsigned VPN_BITS = 20,
    parameter int unsigned PPN_BITS = 20,
    parameter int unsigned WAYW     = 2
) (
    input  logic [NUM_WAYS-1:0]               i_valid,
    input  logic [NUM_WAYS-1:0][VPN_BITS-1:0] i_vpn,
    input  logic [NUM_WAYS-1:0][PPN_BITS-1:0] i_ppn,
    input  logic [NUM_WAYS-1:0][1:0]          i_perms,
    input  logic [VPN_BITS-1:0]               i_target,
    output logic                              o_match,
    output logic [WAYW-1:0]                   o_way,
    output logic [PPN_BITS-1:0]               o_ppn,
    output logic [1:0]                        o_perms
);

    // Scan from the top way down so the lowest matching way is the last written.
    always_comb begin
        o_match = 1'b0;
        o_way   = '0;
        o_ppn   = '0;
        o_perms = 2'b00;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (i_valid[w] && (i_vpn[w] == i_target)) begin
                o_match = 1'b1;
                o_way   = WAYW'(w);
                o_ppn   = i_ppn[w];
                o_perms = i_perms[w];
            end else begin
                o_match = o_match;
            end
        end
    end

endmodule

// File: rtl/tlb_set_assoc.sv
// Set-associative TLB: registered two-edge lookup, fill with round-robin
// replacement, single-entry invalidate and a one-set-per-cycle full flush.
module tlb_set_assoc
    import tlb_pkg::*;
#(
    parameter int unsigned NUM_SETS  = 16,
    parameter int unsigned NUM_WAYS  = 4,
    parameter int unsigned VA_BITS   = 32,
    parameter int unsigned PA_BITS   = 32,
    parameter int unsigned PAGE_BITS = 12
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [VA_BITS-1:0]               req_vaddr,
    input  logic                             req_write,
    output logic                             resp_valid,
    output logic                             resp_hit,
    output logic [log2_width(NUM_WAYS)-1:0]  resp_way,
    output logic [PA_BITS-1:0]               resp_paddr,
    output logic                             resp_perm_fault,
    input  logic                             fill_valid,
    input  logic [VA_BITS-PAGE_BITS-1:0]     fill_vpn,
    input  logic [PA_BITS-PAGE_BITS-1:0]     fill_ppn,
    input  logic [1:0]                       fill_perms,
    input  logic                             inv_valid,
    input  logic                             inv_all,
    input  logic [VA_BITS-PAGE_BITS-1:0]     inv_vpn,
    output logic                             inv_done
);

    localparam int unsigned VPN_BITS = VA_BITS - PAGE_BITS;
    localparam int unsigned PPN_BITS = PA_BITS - PAGE_BITS;
    localparam int unsigned SETW     = log2_width(NUM_SETS);
    localparam int unsigned WAYW     = log2_width(NUM_WAYS);

    logic [NUM_SETS-1:0][NUM_WAYS-1:0]               r_valid;
    logic [NUM_SETS-1:0][WAYW-1:0]                   r_rr;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0][VPN_BITS-1:0] r_vpn;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0][PPN_BITS-1:0] r_ppn;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0][1:0]          r_perms;

    tlb_state_e        r_state, w_state_nxt;
    logic [SETW-1:0]   r_flush_cnt, w_flush_cnt_nxt;
    logic              r_inv_done, w_inv_done_nxt;
    logic              r_alive;

    logic                 r_req_valid;
    logic [VPN_BITS-1:0]  r_req_vpn;
    logic [PAGE_BITS-1:0] r_req_off;
    logic                 r_req_write;

    logic                 r_resp_valid, r_resp_hit, r_resp_fault;
    logic [WAYW-1:0]      r_resp_way;
    logic [PA_BITS-1:0]   r_resp_paddr;

    logic                 w_idle, w_inv_go, w_fill_go, w_req_go;
    logic [VPN_BITS-1:0]  w_mnt_vpn;
    logic [SETW-1:0]      w_mnt_set, w_req_set;
    logic                 w_mnt_match, w_lk_match;
    logic [WAYW-1:0]      w_mnt_way, w_lk_way, w_victim;
    logic [PPN_BITS-1:0]  w_mnt_ppn, w_lk_ppn;
    logic [1:0]           w_mnt_perms, w_lk_perms;
    logic                 w_evict, w_fill_same;

    assign w_idle    = (r_state == IDLE);
    assign w_inv_go  = w_idle && inv_valid;
    assign w_fill_go = w_idle && !inv_valid && fill_valid;
    assign req_ready = r_alive && w_idle && !inv_valid && !fill_valid;
    assign w_req_go  = req_valid && req_ready;

    // Fill and invalidate share one matcher; invalidate has priority.
    assign w_mnt_vpn = inv_valid ? inv_vpn : fill_vpn;
    assign w_mnt_set = w_mnt_vpn[SETW-1:0];
    assign w_req_set = r_req_vpn[SETW-1:0];

    tlb_way_match #(
        .NUM_WAYS (NUM_WAYS),
        .VPN_BITS (VPN_BITS),
        .PPN_BITS (PPN_BITS),
        .WAYW     (WAYW)
    ) u_lookup_match (
        .i_valid  (r_valid[w_req_set]),
        .i_vpn    (r_vpn[w_req_set]),
        .i_ppn    (r_ppn[w_req_set]),
        .i_perms  (r_perms[w_req_set]),
        .i_target (r_req_vpn),
        .o_match  (w_lk_match),
        .o_way    (w_lk_way),
        .o_ppn    (w_lk_ppn),
        .o_perms  (w_lk_perms)
    );

    tlb_way_match #(
        .NUM_WAYS (NUM_WAYS),
        .VPN_BITS (VPN_BITS),
        .PPN_BITS (PPN_BITS),
        .WAYW     (WAYW)
    ) u_maint_match (
        .i_valid  (r_valid[w_mnt_set]),
        .i_vpn    (r_vpn[w_mnt_set]),
        .i_ppn    (r_ppn[w_mnt_set]),
        .i_perms  (r_perms[w_mnt_set]),
        .i_target (w_mnt_vpn),
        .o_match  (w_mnt_match),
        .o_way    (w_mnt_way),
        .o_ppn    (w_mnt_ppn),
        .o_perms  (w_mnt_perms)
    );

    // An identical re-fill leaves the data arrays untouched.
    assign w_fill_same = w_mnt_match && (w_mnt_ppn == fill_ppn) && (w_mnt_perms == fill_perms);

    // Victim choice: in-place hit, else lowest free way, else round-robin eviction.
    always_comb begin
        w_victim = r_rr[w_mnt_set];
        w_evict  = 1'b0;
        if (w_mnt_match) begin
            w_victim = w_mnt_way;
        end else if (!(&r_valid[w_mnt_set])) begin
            for (int w = NUM_WAYS - 1; w >= 0; w--) begin
                if (!r_valid[w_mnt_set][w]) begin
                    w_victim = WAYW'(w);
                end else begin
                    w_victim = w_victim;
                end
            end
        end else begin
            w_evict = 1'b1;
        end
    end

    // Controller next-state: single invalidates ack next cycle, flush walks every set.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_inv_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (inv_valid && inv_all) begin
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = '0;
                end else if (inv_valid) begin
                    w_inv_done_nxt = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (r_flush_cnt == SETW'(NUM_SETS - 1)) begin
                    w_state_nxt     = IDLE;
                    w_flush_cnt_nxt = '0;
                    w_inv_done_nxt  = 1'b1;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt + SETW'(1);
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_flush_cnt_nxt = '0;
            end
        endcase
    end

    // Controller state, flush counter and invalidate acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_flush_cnt <= '0;
            r_inv_done  <= 1'b0;
            r_alive     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_inv_done  <= w_inv_done_nxt;
            r_alive     <= 1'b1;
        end
    end

    // Valid bits and replacement pointers: the only storage cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_rr    <= '0;
        end else if (r_state == FLUSH) begin
            r_valid[r_flush_cnt] <= '0;
        end else if (w_inv_go) begin
            if (!inv_all && w_mnt_match) begin
                r_valid[w_mnt_set][w_mnt_way] <= 1'b0;
            end
        end else if (w_fill_go) begin
            r_valid[w_mnt_set][w_victim] <= 1'b1;
            if (w_evict) begin
                r_rr[w_mnt_set] <= r_rr[w_mnt_set] + WAYW'(1);
            end
        end
    end

    // Translation payload written on fill.
    always_ff @(posedge clk) begin
        if (w_fill_go && !w_fill_same) begin
            r_vpn[w_mnt_set][w_victim]   <= fill_vpn;
            r_ppn[w_mnt_set][w_victim]   <= fill_ppn;
            r_perms[w_mnt_set][w_victim] <= fill_perms;
        end
    end

    // First lookup stage: capture the accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_valid <= 1'b0;
            r_req_vpn   <= '0;
            r_req_off   <= '0;
            r_req_write <= 1'b0;
        end else begin
            r_req_valid <= w_req_go;
            if (w_req_go) begin
                r_req_vpn   <= req_vaddr[VA_BITS-1:PAGE_BITS];
                r_req_off   <= req_vaddr[PAGE_BITS-1:0];
                r_req_write <= req_write;
            end
        end
    end

    // Second lookup stage: register the response; a miss returns all zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_way   <= '0;
            r_resp_paddr <= '0;
            r_resp_fault <= 1'b0;
        end else begin
            r_resp_valid <= r_req_valid;
            if (r_req_valid && w_lk_match) begin
                r_resp_hit   <= 1'b1;
                r_resp_way   <= w_lk_way;
                r_resp_paddr <= {w_lk_ppn, r_req_off};
                r_resp_fault <= r_req_write ? !w_lk_perms[PERM_W] : !w_lk_perms[PERM_R];
            end else begin
                r_resp_hit   <= 1'b0;
                r_resp_way   <= '0;
                r_resp_paddr <= '0;
                r_resp_fault <= 1'b0;
            end
        end
    end

    assign resp_valid      = r_resp_valid;
    assign resp_hit        = r_resp_hit;
    assign resp_way        = r_resp_way;
    assign resp_paddr      = r_resp_paddr;
    assign resp_perm_fault = r_resp_fault;
    assign inv_done        = r_inv_done;

endmodule

// File: tb/tb_tlb_set_assoc.sv
// Directed self-checking bench for tlb_set_assoc with default parameters
// (16 sets, 4 ways, 32-bit VA/PA, 4 KiB pages).
module tb_tlb_set_assoc;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_vaddr;
    logic        resp_valid, resp_hit, resp_perm_fault;
    logic [1:0]  resp_way;
    logic [31:0] resp_paddr;
    logic        fill_valid;
    logic [19:0] fill_vpn, fill_ppn;
    logic [1:0]  fill_perms;
    logic        inv_valid, inv_all, inv_done;
    logic [19:0] inv_vpn;

    int n_err;
    int n_chk;

    logic        lv, lh, lf;
    logic [1:0]  lw;
    logic [31:0] lpa;

    tlb_set_assoc dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_vaddr       (req_vaddr),
        .req_write       (req_write),
        .resp_valid      (resp_valid),
        .resp_hit        (resp_hit),
        .resp_way        (resp_way),
        .resp_paddr      (resp_paddr),
        .resp_perm_fault (resp_perm_fault),
        .fill_valid      (fill_valid),
        .fill_vpn        (fill_vpn),
        .fill_ppn        (fill_ppn),
        .fill_perms      (fill_perms),
        .inv_valid       (inv_valid),
        .inv_all         (inv_all),
        .inv_vpn         (inv_vpn),
        .inv_done        (inv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input logic [31:0] va, input logic wr);
        req_valid = 1'b1;
        req_vaddr = va;
        req_write = wr;
        tick();
        req_valid = 1'b0;
        tick();
        lv  = resp_valid;
        lh  = resp_hit;
        lw  = resp_way;
        lpa = resp_paddr;
        lf  = resp_perm_fault;
    endtask

    task automatic do_fill(input logic [19:0] vpn, input logic [19:0] ppn, input logic [1:0] perms);
        fill_valid = 1'b1;
        fill_vpn   = vpn;
        fill_ppn   = ppn;
        fill_perms = perms;
        tick();
        fill_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({req_ready, resp_valid, resp_hit, resp_way, resp_paddr, resp_perm_fault, inv_done} !== 38'd0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%0b valid=%0b hit=%0b way=%0d pa=%h fault=%0b done=%0b, want all 0",
                     req_ready, resp_valid, resp_hit, resp_way, resp_paddr, resp_perm_fault, inv_done);
        end
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset: got %0b want 1", req_ready);
        end
        do_lookup(32'h1234_5678, 1'b0);
        n_chk++;
        if ({lv, lh, lw, lpa, lf} !== {1'b1, 1'b0, 2'd0, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL first_lookup_miss: v=%0b h=%0b w=%0d pa=%h f=%0b want v=1 h=0 w=0 pa=0 f=0", lv, lh, lw, lpa, lf);
        end
        n_chk++;
        if (resp_valid !== 1'b0) begin
            tick();
        end
        tick();
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL resp_single_pulse: got %0b want 0", resp_valid);
        end
    endtask

    task automatic test_fill_perm();
        do_fill(20'h12345, 20'h54321, 2'b01);
        do_lookup(32'h1234_5ABC, 1'b0);
        n_chk++;
        if ({lv, lh, lpa, lf} !== {1'b1, 1'b1, 32'h5432_1ABC, 1'b0}) begin
            n_err++;
            $display("FAIL fill_read_hit: v=%0b h=%0b pa=%h f=%0b want 1 1 54321abc 0", lv, lh, lpa, lf);
        end
        do_lookup(32'h1234_5ABC, 1'b1);
        n_chk++;
        if ({lv, lh, lpa, lf} !== {1'b1, 1'b1, 32'h5432_1ABC, 1'b1}) begin
            n_err++;
            $display("FAIL write_perm_fault: v=%0b h=%0b pa=%h f=%0b want 1 1 54321abc 1", lv, lh, lpa, lf);
        end
    endtask

    task automatic test_single_inv();
        do_fill(20'h0ABC6, 20'h11111, 2'b11);
        inv_valid = 1'b1;
        inv_all   = 1'b0;
        inv_vpn   = 20'h12345;
        #1;
        n_chk++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL inv_blocks_ready: got %0b want 0", req_ready);
        end
        tick();
        inv_valid = 1'b0;
        n_chk++;
        if (inv_done !== 1'b1) begin
            n_err++;
            $display("FAIL inv_done_pulse: got %0b want 1", inv_done);
        end
        do_lookup(32'h1234_5000, 1'b0);
        n_chk++;
        if ({lv, lh} !== 2'b10) begin
            n_err++;
            $display("FAIL inv_entry_miss: v=%0b h=%0b want v=1 h=0", lv, lh);
        end
        do_lookup(32'h0ABC_6123, 1'b1);
        n_chk++;
        if ({lh, lpa, lf} !== {1'b1, 32'h1111_1123, 1'b0}) begin
            n_err++;
            $display("FAIL inv_other_kept: h=%0b pa=%h f=%0b want 1 11111123 0", lh, lpa, lf);
        end
        inv_valid = 1'b1;
        inv_vpn   = 20'h99999;
        tick();
        inv_valid = 1'b0;
        n_chk++;
        if (inv_done !== 1'b1) begin
            n_err++;
            $display("FAIL inv_miss_ack: got %0b want 1", inv_done);
        end
    endtask

    task automatic test_replacement();
        logic [19:0] vpns [0:6];
        logic [1:0]  ways [0:6];
        logic [19:0] v;
        vpns[0] = 20'h00005; vpns[1] = 20'h00015; vpns[2] = 20'h00025; vpns[3] = 20'h00035;
        vpns[4] = 20'h00045; vpns[5] = 20'h00055; vpns[6] = 20'h00065;
        for (int i = 0; i < 5; i++) begin
            v = vpns[i];
            do_fill(v, 20'hA0000 | v, 2'b11);
        end
        // After five fills way 0 holds 0x45; 0x15/0x25/0x35 stay in ways 1..3.
        ways[1] = 2'd1; ways[2] = 2'd2; ways[3] = 2'd3; ways[4] = 2'd0;
        do_lookup(32'h0000_5000, 1'b0);
        n_chk++;
        if ({lv, lh} !== 2'b10) begin
            n_err++;
            $display("FAIL repl_evicted_way0: v=%0b h=%0b want v=1 h=0", lv, lh);
        end
        for (int i = 1; i < 5; i++) begin
            v = vpns[i];
            do_lookup({v, 12'h000}, 1'b0);
            n_chk++;
            if ({lh, lw, lpa} !== {1'b1, ways[i], (20'hA0000 | v), 12'h000}) begin
                n_err++;
                $display("FAIL repl_hit_%0d: h=%0b w=%0d pa=%h want h=1 w=%0d pa=%h",
                         i, lh, lw, lpa, ways[i], {(20'hA0000 | v), 12'h000});
            end
        end
        do_fill(vpns[5], 20'hA0055, 2'b11);
        do_lookup(32'h0001_5000, 1'b0);
        n_chk++;
        if (lh !== 1'b0) begin
            n_err++;
            $display("FAIL repl_sixth_evicts_way1: hit=%0b want 0", lh);
        end
        do_lookup(32'h0005_5000, 1'b0);
        n_chk++;
        if ({lh, lw} !== {1'b1, 2'd1}) begin
            n_err++;
            $display("FAIL repl_sixth_way: h=%0b w=%0d want h=1 w=1", lh, lw);
        end
        // In-place refill of 0x25 keeps way 2 and must not advance the pointer.
        do_fill(vpns[2], 20'h0D025, 2'b11);
        do_lookup(32'h0002_5000, 1'b0);
        n_chk++;
        if ({lh, lw, lpa} !== {1'b1, 2'd2, 32'h0D02_5000}) begin
            n_err++;
            $display("FAIL refill_in_place: h=%0b w=%0d pa=%h want 1 2 0d025000", lh, lw, lpa);
        end
        do_fill(vpns[6], 20'hA0065, 2'b11);
        do_lookup(32'h0006_5000, 1'b0);
        n_chk++;
        if ({lh, lw} !== {1'b1, 2'd2}) begin
            n_err++;
            $display("FAIL rr_not_advanced_by_refill: h=%0b w=%0d want h=1 w=2", lh, lw);
        end
    endtask

    task automatic test_collision();
        fill_valid = 1'b1;
        fill_vpn   = 20'h0000A;
        fill_ppn   = 20'h0BEEF;
        fill_perms = 2'b11;
        req_valid  = 1'b1;
        req_vaddr  = 32'h0000_A010;
        req_write  = 1'b0;
        #1;
        n_chk++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL collision_ready: got %0b want 0", req_ready);
        end
        tick();
        fill_valid = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        n_chk++;
        if ({resp_valid, resp_hit, resp_paddr} !== {1'b1, 1'b1, 32'h0BEE_F010}) begin
            n_err++;
            $display("FAIL collision_held_hit: v=%0b h=%0b pa=%h want 1 1 0beef010", resp_valid, resp_hit, resp_paddr);
        end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_vaddr = 32'h0000_A004;
        tick();
        req_vaddr = 32'h0ABC_6008;
        tick();
        req_valid  = 1'b0;
        n_chk++;
        if ({resp_valid, resp_hit, resp_paddr} !== {1'b1, 1'b1, 32'h0BEE_F004}) begin
            n_err++;
            $display("FAIL b2b_first: v=%0b h=%0b pa=%h want 1 1 0beef004", resp_valid, resp_hit, resp_paddr);
        end
        // Fill on the response edge must not disturb the second response.
        fill_valid = 1'b1;
        fill_vpn   = 20'h0ABC6;
        fill_ppn   = 20'h0CAFE;
        fill_perms = 2'b11;
        tick();
        fill_valid = 1'b0;
        n_chk++;
        if ({resp_valid, resp_hit, resp_paddr} !== {1'b1, 1'b1, 32'h1111_1008}) begin
            n_err++;
            $display("FAIL b2b_second: v=%0b h=%0b pa=%h want 1 1 11111008", resp_valid, resp_hit, resp_paddr);
        end
        do_lookup(32'h0ABC_6008, 1'b0);
        n_chk++;
        if ({lh, lpa} !== {1'b1, 32'h0CAF_E008}) begin
            n_err++;
            $display("FAIL b2b_fill_visible: h=%0b pa=%h want 1 0cafe008", lh, lpa);
        end
    endtask

    task automatic test_flush();
        int low_cycles;
        int done_pulses;
        int guard;
        do_fill(20'h00010, 20'h22222, 2'b11);
        do_fill(20'h0001F, 20'h33333, 2'b11);
        inv_valid   = 1'b1;
        inv_all     = 1'b1;
        low_cycles  = 0;
        done_pulses = 0;
        guard       = 0;
        #1;
        if (req_ready === 1'b0) low_cycles++;
        tick();
        inv_valid = 1'b0;
        inv_all   = 1'b0;
        while (req_ready !== 1'b1 && guard < 40) begin
            low_cycles++;
            if (inv_done === 1'b1) done_pulses++;
            fill_valid = (guard == 4);
            fill_vpn   = 20'h00077;
            fill_ppn   = 20'h44444;
            fill_perms = 2'b11;
            tick();
            guard++;
        end
        fill_valid = 1'b0;
        if (inv_done === 1'b1) done_pulses++;
        tick();
        if (inv_done === 1'b1) done_pulses++;
        n_chk++;
        if (low_cycles != 17) begin
            n_err++;
            $display("FAIL flush_ready_low: got %0d cycles want 17", low_cycles);
        end
        n_chk++;
        if (done_pulses != 1) begin
            n_err++;
            $display("FAIL flush_done_once: got %0d pulses want 1", done_pulses);
        end
        do_lookup(32'h0001_0000, 1'b0);
        n_chk++;
        if ({lv, lh} !== 2'b10) begin
            n_err++;
            $display("FAIL flush_set0_miss: v=%0b h=%0b want 1 0", lv, lh);
        end
        do_lookup(32'h0001_F000, 1'b0);
        n_chk++;
        if ({lv, lh} !== 2'b10) begin
            n_err++;
            $display("FAIL flush_set15_miss: v=%0b h=%0b want 1 0", lv, lh);
        end
        do_lookup(32'h0007_7000, 1'b0);
        n_chk++;
        if (lh !== 1'b0) begin
            n_err++;
            $display("FAIL fill_during_flush_ignored: hit=%0b want 0", lh);
        end
    endtask

    task automatic test_reset_mid_flush();
        do_fill(20'h12345, 20'h54321, 2'b11);
        do_fill(20'h0001F, 20'h33333, 2'b11);
        inv_valid = 1'b1;
        inv_all   = 1'b1;
        tick();
        inv_valid = 1'b0;
        inv_all   = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({req_ready, resp_valid, resp_hit, resp_way, resp_paddr, resp_perm_fault, inv_done} !== 38'd0) begin
            n_err++;
            $display("FAIL midflush_reset_outputs: ready=%0b valid=%0b hit=%0b pa=%h done=%0b want all 0",
                     req_ready, resp_valid, resp_hit, resp_paddr, inv_done);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midflush_back_idle: ready=%0b want 1", req_ready);
        end
        do_lookup(32'h1234_5ABC, 1'b0);
        n_chk++;
        if ({lv, lh} !== 2'b10) begin
            n_err++;
            $display("FAIL midflush_entry_cleared: v=%0b h=%0b want 1 0", lv, lh);
        end
        do_lookup(32'h0001_F000, 1'b0);
        n_chk++;
        if ({lv, lh} !== 2'b10) begin
            n_err++;
            $display("FAIL midflush_set15_cleared: v=%0b h=%0b want 1 0", lv, lh);
        end
    endtask

    initial begin
        n_err      = 0;
        n_chk      = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_vaddr  = 32'h0;
        req_write  = 1'b0;
        fill_valid = 1'b0;
        fill_vpn   = 20'h0;
        fill_ppn   = 20'h0;
        fill_perms = 2'b00;
        inv_valid  = 1'b0;
        inv_all    = 1'b0;
        inv_vpn    = 20'h0;
        test_reset();
        test_fill_perm();
        test_single_inv();
        test_replacement();
        test_collision();
        test_back_to_back();
        test_flush();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
